if_stage: RTL
=============

Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage pipeline. It holds the program counter and drives the instruction-memory address. It captures the fetched word into the IF/ID pipeline register consumed by the decode stage. It applies the stall request from hazard detection and the taken-branch/jump redirect from EX, and keeps a saturating fetched-instruction counter for debug.

Parameters:
PC_W, 32, program counter / address width in bits
INSTR_W, 32, instruction word width
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 16, width of the fetched-instruction counter

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hazard unit request; hold PC and IF/ID
redirect  in  1  taken branch/jump resolved in EX
redirect_pc  in  PC_W  target address for redirect
imem_addr  out  PC_W  instruction-memory address, combinational from PC
imem_data  in  INSTR_W  instruction word, combinational read of imem_addr
ifid_instr  out  INSTR_W  registered instruction to decode
ifid_pc4  out  PC_W  registered PC+4 of that instruction
ifid_valid  out  1  1 = ifid_instr is a real instruction, 0 = bubble
pc  out  PC_W  current program counter
fetch_cnt  out  CNT_W  number of instructions loaded into IF/ID, saturating

Behaviour:
- Reset (synchronous, active-high; takes priority over everything): pc=RESET_PC, ifid_instr=NOP (all zeros), ifid_pc4=0, ifid_valid=0, fetch_cnt=0. Reset asserted mid-stall or mid-redirect discards the pending event.
- imem_addr = {pc[PC_W-1:2], 2'b00}; pure combinational, no added latency. Instruction is available in IF/ID one cycle after its PC is presented.
- Per-edge priority: reset > redirect > stall > normal.
- Normal (no stall, no redirect):
  - pc <= pc+4
  - ifid_instr <= imem_data
  - ifid_pc4 <= pc+4
  - ifid_valid <= 1
  - fetch_cnt increments
- Stall only: pc, ifid_instr, ifid_pc4, ifid_valid, fetch_cnt all hold.
- Redirect (stall ignored when both are asserted):
  - pc <= {redirect_pc[PC_W-1:2], 2'b00}
  - IF/ID flushed to bubble: ifid_instr=NOP, ifid_pc4=0, ifid_valid=0
  - fetch_cnt does not increment
- Misaligned redirect target: low 2 bits are silently forced to 0. No error output.
- PC arithmetic is modulo 2^PC_W. pc = 2^PC_W-4 wraps to 0 with no flag.
- fetch_cnt saturates at 2^CNT_W-1 and never wraps.
- redirect held for several cycles: each cycle reloads the target and inserts a bubble.
- No combinational path from stall or redirect to any output except through registers. imem_addr depends on pc only.

Decomposition:
- Shared package pipeline_pkg:
  - NOP_INSTR (32'h0000_0000)
  - PC_INC (4)
  - PC_W / INSTR_W defaults, reused by id/ex/mem/wb stages
- One natural sub-module, pc_reg: PC register with next-PC mux (reset/redirect/stall/increment).
- IF/ID register and counter stay in if_stage.

Test Plan:
- Reset then 4 free-running cycles, imem_data = 0x20080001, 0x20090002, 0x01095020, 0xAC0A0000 at addresses 0, 4, 8, 12 -> imem_addr 0, 4, 8, 12. ifid_instr follows one cycle later with ifid_pc4 4, 8, 12, 16. ifid_valid=1 from cycle 1. fetch_cnt=4.
- stall high 2 cycles at pc=8 -> pc stays 8, ifid_instr stays 0x20090002, fetch_cnt frozen. Release -> pc=12, ifid_instr=0x01095020.
- redirect=1 with redirect_pc=0x40 and stall=1 in the same cycle at pc=12 -> next pc=0x40, ifid_valid=0, ifid_instr=0. The following cycle loads the word at 0x40 with ifid_pc4=0x44.
- redirect_pc=0x43 -> pc=0x40, imem_addr=0x40.
- Wrap and saturation, run with CNT_W=4:
  - pc forced via redirect to 0xFFFF_FFFC, one normal cycle -> pc=0, ifid_pc4=0.
  - 20 normal cycles -> fetch_cnt=15 and holds.
- reset asserted while stall=1 and redirect=1 -> next edge pc=RESET_PC, ifid_valid=0, fetch_cnt=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants reused by the IF/ID/EX/MEM/WB stages.
package pipeline_pkg;
  localparam int PC_W_DEF    = 32;
  localparam int INSTR_W_DEF = 32;
  localparam int PC_INC      = 4;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/if_stage_if.sv
// Bus between the fetch stage, instruction memory, hazard unit, EX redirect and decode.
interface if_stage_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
);
  // ifid_valid qualifies ifid_instr/ifid_pc4 every cycle: 1 = real instruction,
  // 0 = bubble. Decode has no back-pressure; the hazard unit holds IF/ID via stall.
  logic               stall;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] ifid_instr;
  logic [PC_W-1:0]    ifid_pc4;
  logic               ifid_valid;
  logic [PC_W-1:0]    pc;
  logic [CNT_W-1:0]   fetch_cnt;

  modport master (
    input  stall, redirect, redirect_pc, imem_data,
    output imem_addr, ifid_instr, ifid_pc4, ifid_valid, pc, fetch_cnt
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_data,
    input  imem_addr, ifid_instr, ifid_pc4, ifid_valid, pc, fetch_cnt
  );
endinterface

// File: rtl/if_stage_pc_reg.sv
// Program counter register with next-PC selection (reset > redirect > stall > increment).
module pc_reg
  import pipeline_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  output logic [PC_W-1:0] pc_o
);
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Misaligned redirect targets are quietly word-aligned; wrap is modulo 2^PC_W.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = {redirect_pc_i[PC_W-1:2], 2'b00};
    end else if (!stall_i) begin
      pc_d = pc_q + PC_W'(PC_INC);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem address, IF/ID register and saturating fetch counter.
module if_stage
  import pipeline_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic       clk,
  input  logic       reset,
  if_stage_if.master bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_plus4;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc4_q, pc4_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk_i         (clk),
    .reset_i       (reset),
    .stall_i       (bus.stall),
    .redirect_i    (bus.redirect),
    .redirect_pc_i (bus.redirect_pc),
    .pc_o          (pc)
  );

  assign pc_plus4 = pc + PC_W'(PC_INC);

  // Redirect wins over stall: the wrong-path fetch is squashed to a bubble.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (bus.redirect) begin
      instr_d = INSTR_W'(NOP_INSTR);
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (!bus.stall) begin
      instr_d = bus.imem_data;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= INSTR_W'(NOP_INSTR);
      pc4_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.imem_addr  = {pc[PC_W-1:2], 2'b00};
  assign bus.pc         = pc;
  assign bus.ifid_instr = instr_q;
  assign bus.ifid_pc4   = pc4_q;
  assign bus.ifid_valid = valid_q;
  assign bus.fetch_cnt  = cnt_q;
endmodule
